// File: rtl/mips_ctrl_pkg.sv
// Shared decode constants and the ID/EX control bundle for the pipelined MIPS control unit.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_NOP   = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd3,
    ALU_SLT = 3'd4
  } alu_cmd_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_JUMP = 2'd1,
    BR_BNE  = 2'd2,
    BR_BEZ  = 2'd3
  } br_cmd_e;

  typedef struct packed {
    logic     mem_read;
    logic     mem_write;
    logic     reg_write;
    logic     alu_src;
    logic     is_br;
    logic     is_imm;
    logic     store_or_branch;
    alu_cmd_e alu_cmd;
    br_cmd_e  br_cmd;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode/funct decode: control bundle, write-back register,
// whether Rt is read as a source, and an illegal-instruction flag.
module ctrl_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter bit EN_IMM_ALU = 1'b1
) (
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  output ctrl_t                 ctrl,
  output logic [REG_ADDR_W-1:0] dest,
  output logic                  uses_rt,
  output logic                  illegal
);

  always_comb begin
    ctrl    = CTRL_BUBBLE;
    dest    = '0;
    uses_rt = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_LW: begin
        ctrl.mem_read        = 1'b1;
        ctrl.reg_write       = 1'b1;
        ctrl.is_imm          = 1'b1;
        ctrl.alu_src         = 1'b1;
        ctrl.store_or_branch = 1'b1;
        ctrl.alu_cmd         = ALU_ADD;
        dest                 = rt;
      end
      OP_SW: begin
        ctrl.mem_write       = 1'b1;
        ctrl.is_imm          = 1'b1;
        ctrl.alu_src         = 1'b1;
        ctrl.store_or_branch = 1'b1;
        ctrl.alu_cmd         = ALU_ADD;
        uses_rt              = 1'b1;
      end
      OP_J: begin
        ctrl.br_cmd  = BR_JUMP;
        ctrl.is_br   = 1'b1;
        ctrl.is_imm  = 1'b1;
        ctrl.alu_src = 1'b1;
      end
      OP_BEQ: begin
        ctrl.br_cmd  = BR_BEZ;
        ctrl.is_br   = 1'b1;
        ctrl.is_imm  = 1'b1;
        ctrl.alu_src = 1'b1;
        uses_rt      = 1'b1;
      end
      OP_BNE: begin
        ctrl.br_cmd          = BR_BNE;
        ctrl.is_br           = 1'b1;
        ctrl.is_imm          = 1'b1;
        ctrl.alu_src         = 1'b1;
        ctrl.store_or_branch = 1'b1;
        uses_rt              = 1'b1;
      end
      OP_NOP: ;
      OP_RTYPE: begin
        uses_rt        = 1'b1;
        ctrl.reg_write = 1'b1;
        dest           = rd;
        case (funct)
          FN_ADD:  ctrl.alu_cmd = ALU_ADD;
          FN_SUB:  ctrl.alu_cmd = ALU_SUB;
          FN_AND:  ctrl.alu_cmd = ALU_AND;
          FN_OR:   ctrl.alu_cmd = ALU_OR;
          FN_SLT:  ctrl.alu_cmd = ALU_SLT;
          default: begin
            ctrl    = CTRL_BUBBLE;
            dest    = '0;
            illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        if (EN_IMM_ALU) begin
          ctrl.reg_write = 1'b1;
          ctrl.is_imm    = 1'b1;
          ctrl.alu_src   = 1'b1;
          dest           = rt;
          case (opcode)
            OP_ANDI: ctrl.alu_cmd = ALU_AND;
            OP_ORI:  ctrl.alu_cmd = ALU_OR;
            OP_SLTI: ctrl.alu_cmd = ALU_SLT;
            default: ctrl.alu_cmd = ALU_ADD;
          endcase
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// ID-stage control: decode into the ID/EX control register, load-use hazard
// detection and a stall FSM that injects LOAD_STALL bubbles per hazard.
module pipelined_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 3,
  parameter int LOAD_STALL = 1,
  parameter bit EN_IMM_ALU = 1'b1
) (
  input  logic                  clk,
  input  logic                  Rst,
  input  logic [5:0]            Opcode,
  input  logic [5:0]            Function,
  input  logic [REG_ADDR_W-1:0] IdRs,
  input  logic [REG_ADDR_W-1:0] IdRt,
  input  logic [REG_ADDR_W-1:0] IdRd,
  input  logic                  IdValid,
  input  logic                  Flush,
  output logic                  Stall,
  output logic                  ExMemRead,
  output logic                  ExMemWrite,
  output logic                  ExRegWrite,
  output logic                  ExALUSrc,
  output logic                  ExIsBr,
  output logic                  ExIsImm,
  output logic                  ExStoreOrBranch,
  output logic [ALU_OP_W-1:0]   ExALUOprand,
  output logic [1:0]            ExBranchCommand,
  output logic [REG_ADDR_W-1:0] ExDest,
  output logic                  ExValid,
  output logic                  IllegalOp
);

  typedef enum logic {S_IDLE, S_STALL} state_e;

  // First hazard cycle is spent in IDLE, so the counter covers the remaining LOAD_STALL-1.
  localparam logic [1:0] STALL_RELOAD = (LOAD_STALL > 1) ? 2'(LOAD_STALL - 2) : 2'd0;

  state_e                state;
  logic [1:0]            cnt;
  ctrl_t                 ex_ctrl;
  logic [REG_ADDR_W-1:0] ex_dest;
  logic                  ex_valid;
  logic                  illegal_op;

  ctrl_t                 dec_ctrl;
  ctrl_t                 ld_ctrl;
  logic [REG_ADDR_W-1:0] dec_dest;
  logic                  dec_uses_rt;
  logic                  dec_illegal;
  logic                  hazard;

  ctrl_decoder #(
    .REG_ADDR_W (REG_ADDR_W),
    .EN_IMM_ALU (EN_IMM_ALU)
  ) u_decoder (
    .opcode  (Opcode),
    .funct   (Function),
    .rt      (IdRt),
    .rd      (IdRd),
    .ctrl    (dec_ctrl),
    .dest    (dec_dest),
    .uses_rt (dec_uses_rt),
    .illegal (dec_illegal)
  );

  always_comb begin
    ld_ctrl           = dec_ctrl;
    ld_ctrl.reg_write = dec_ctrl.reg_write & (dec_dest != '0);
  end

  assign hazard = ex_valid & ex_ctrl.mem_read & (ex_dest != '0) & IdValid &
                  ((ex_dest == IdRs) | (dec_uses_rt & (ex_dest == IdRt)));

  assign Stall = ~Flush & ((state == S_STALL) | hazard);

  // Every path loads a bubble by default; only a clean IDLE issue overrides it.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      ex_ctrl    <= CTRL_BUBBLE;
      ex_dest    <= '0;
      ex_valid   <= 1'b0;
      illegal_op <= 1'b0;
      state      <= S_IDLE;
      cnt        <= '0;
    end else begin
      ex_ctrl    <= CTRL_BUBBLE;
      ex_dest    <= '0;
      ex_valid   <= 1'b0;
      illegal_op <= 1'b0;
      if (Flush) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (hazard) begin
              if (LOAD_STALL > 1) begin
                state <= S_STALL;
                cnt   <= STALL_RELOAD;
              end
            end else if (IdValid && dec_illegal) begin
              illegal_op <= 1'b1;
            end else begin
              ex_ctrl  <= ld_ctrl;
              ex_dest  <= dec_dest;
              ex_valid <= IdValid;
            end
          end
          S_STALL: begin
            if (cnt == '0) state <= S_IDLE;
            else           cnt   <= cnt - 2'd1;
          end
          default: begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign ExMemRead       = ex_ctrl.mem_read;
  assign ExMemWrite      = ex_ctrl.mem_write;
  assign ExRegWrite      = ex_ctrl.reg_write;
  assign ExALUSrc        = ex_ctrl.alu_src;
  assign ExIsBr          = ex_ctrl.is_br;
  assign ExIsImm         = ex_ctrl.is_imm;
  assign ExStoreOrBranch = ex_ctrl.store_or_branch;
  assign ExALUOprand     = ALU_OP_W'(ex_ctrl.alu_cmd);
  assign ExBranchCommand = ex_ctrl.br_cmd;
  assign ExDest          = ex_dest;
  assign ExValid         = ex_valid;
  assign IllegalOp       = illegal_op;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench: two DUT configurations (LOAD_STALL=1/imm on, LOAD_STALL=3/imm off)
// checked against a cycle-level reference model of the pipeline control rules.
module tb_pipelined_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       Rst;
  logic [5:0] op [2];
  logic [5:0] fn [2];
  logic [4:0] rs [2];
  logic [4:0] rt [2];
  logic [4:0] rd [2];
  logic       idv [2];
  logic       fl [2];

  logic       stall_o [2];
  logic       mr [2], mw [2], rw [2], asrc [2], isbr [2], isimm [2], sob [2];
  logic [2:0] alu [2];
  logic [1:0] br [2];
  logic [4:0] dest [2];
  logic       exv [2], ill [2];

  pipelined_control_unit #(.REG_ADDR_W(5), .ALU_OP_W(3), .LOAD_STALL(1), .EN_IMM_ALU(1'b1)) dut0 (
    .clk(clk), .Rst(Rst), .Opcode(op[0]), .Function(fn[0]), .IdRs(rs[0]), .IdRt(rt[0]),
    .IdRd(rd[0]), .IdValid(idv[0]), .Flush(fl[0]), .Stall(stall_o[0]),
    .ExMemRead(mr[0]), .ExMemWrite(mw[0]), .ExRegWrite(rw[0]), .ExALUSrc(asrc[0]),
    .ExIsBr(isbr[0]), .ExIsImm(isimm[0]), .ExStoreOrBranch(sob[0]), .ExALUOprand(alu[0]),
    .ExBranchCommand(br[0]), .ExDest(dest[0]), .ExValid(exv[0]), .IllegalOp(ill[0]));

  pipelined_control_unit #(.REG_ADDR_W(5), .ALU_OP_W(3), .LOAD_STALL(3), .EN_IMM_ALU(1'b0)) dut1 (
    .clk(clk), .Rst(Rst), .Opcode(op[1]), .Function(fn[1]), .IdRs(rs[1]), .IdRt(rt[1]),
    .IdRd(rd[1]), .IdValid(idv[1]), .Flush(fl[1]), .Stall(stall_o[1]),
    .ExMemRead(mr[1]), .ExMemWrite(mw[1]), .ExRegWrite(rw[1]), .ExALUSrc(asrc[1]),
    .ExIsBr(isbr[1]), .ExIsImm(isimm[1]), .ExStoreOrBranch(sob[1]), .ExALUOprand(alu[1]),
    .ExBranchCommand(br[1]), .ExDest(dest[1]), .ExValid(exv[1]), .IllegalOp(ill[1]));

  int ls [2]     = '{1, 3};
  bit imm_en [2] = '{1'b1, 1'b0};

  typedef struct {
    bit valid, mr, mw, rw, asrc, isbr, isimm, sob, ill, stall, dcare;
    int alu, br, dest;
  } exp_t;

  exp_t q0 [$];
  exp_t q1 [$];
  exp_t mex [2];
  int   left [2];
  int   errors = 0;
  int   checks = 0;
  bit   last_dut_stall;

  logic [5:0] ops [14] = '{6'b100011, 6'b101011, 6'b000010, 6'b000100, 6'b000101, 6'b000001,
                           6'b000000, 6'b000000, 6'b001000, 6'b001100, 6'b001101, 6'b001010,
                           6'b111111, 6'b000011};
  logic [5:0] fns [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};

  function automatic void chk(string nm, int k, int act, int ex);
    checks++;
    if (act != ex) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got %0d expected %0d", nm, k, $time, act, ex);
    end
  endfunction

  // What the instruction means architecturally, independent of pipeline timing.
  function automatic exp_t ref_decode(input logic [5:0] o, input logic [5:0] f, input int rtv,
                                      input int rdv, input bit ien, output bit urt);
    exp_t d = '{default: 0};
    urt = 1'b0;
    case (o)
      6'b100011: begin d.mr = 1; d.rw = 1; d.isimm = 1; d.asrc = 1; d.sob = 1; d.alu = 2;
                       d.dest = rtv; d.dcare = 1; end
      6'b101011: begin d.mw = 1; d.isimm = 1; d.asrc = 1; d.sob = 1; d.alu = 2; urt = 1; end
      6'b000010: begin d.br = 1; d.isbr = 1; d.isimm = 1; d.asrc = 1; end
      6'b000100: begin d.br = 3; d.isbr = 1; d.isimm = 1; d.asrc = 1; urt = 1; end
      6'b000101: begin d.br = 2; d.isbr = 1; d.isimm = 1; d.asrc = 1; d.sob = 1; urt = 1; end
      6'b000001: ;
      6'b000000: begin
        urt = 1;
        case (f)
          6'b100000: d.alu = 2;
          6'b100010: d.alu = 3;
          6'b100100: d.alu = 0;
          6'b100101: d.alu = 1;
          6'b101010: d.alu = 4;
          default:   d.ill = 1;
        endcase
        if (!d.ill) begin d.rw = 1; d.dest = rdv; d.dcare = 1; end
      end
      6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
        if (ien) begin
          d.rw = 1; d.isimm = 1; d.asrc = 1; d.dest = rtv; d.dcare = 1;
          d.alu = (o == 6'b001000) ? 2 : (o == 6'b001100) ? 0 : (o == 6'b001101) ? 1 : 4;
        end else d.ill = 1;
      end
      default: d.ill = 1;
    endcase
    return d;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mex[k]  = '{default: 0};
      left[k] = 0;
    end
  endtask

  task automatic model_cycle(input int k, output bit st);
    exp_t d, e;
    exp_t b = '{default: 0};
    bit urt, hz;
    b.dcare = 1;
    d  = ref_decode(op[k], fn[k], rt[k], rd[k], imm_en[k], urt);
    hz = mex[k].valid && mex[k].mr && mex[k].dest != 0 && idv[k] &&
         (mex[k].dest == rs[k] || (urt && mex[k].dest == rt[k]));
    if (fl[k]) begin
      e = b; left[k] = 0; st = 0;
    end else if (left[k] > 0) begin
      e = b; left[k]--; st = 1;
    end else if (hz) begin
      e = b; left[k] = ls[k] - 1; st = 1;
    end else begin
      st = 0;
      if (idv[k] && d.ill) begin
        e = b; e.ill = 1;
      end else begin
        e = d; e.valid = idv[k]; e.ill = 0;
        if (e.dest == 0) e.rw = 0;
      end
    end
    e.stall = st;
    mex[k]  = e;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic step(input int k, input logic [5:0] o, input logic [5:0] f, input int s,
                      input int t, input int d, input bit v, input bit fls, output bit st);
    op[k] = o; fn[k] = f; rs[k] = 5'(s); rt[k] = 5'(t); rd[k] = 5'(d);
    idv[k] = v; fl[k] = fls;
    model_cycle(k, st);
    #3 last_dut_stall = stall_o[k];
    @(negedge clk);
  endtask

  // Issue one valid instruction, holding it in ID while the pipeline asks to stall.
  task automatic send(input int k, input logic [5:0] o, input logic [5:0] f, input int s,
                      input int t, input int d, output int dut_stalls);
    bit st;
    int n = 0;
    dut_stalls = 0;
    do begin
      step(k, o, f, s, t, d, 1'b1, 1'b0, st);
      if (last_dut_stall) dut_stalls++;
      n++;
    end while (st && n < 8);
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      op[k] = 6'b000001; fn[k] = '0; rs[k] = '0; rt[k] = '0; rd[k] = '0;
      idv[k] = 1'b0; fl[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    Rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    Rst = 1'b1;
    model_reset();
  endtask

  task automatic check_cleared(input int k, input string tag);
    chk({tag, "_stall"}, k, stall_o[k], 0);
    chk({tag, "_ctrl"}, k, {mr[k], mw[k], rw[k], asrc[k], isbr[k], isimm[k], sob[k]}, 0);
    chk({tag, "_alu_br"}, k, {alu[k], br[k]}, 0);
    chk({tag, "_dest"}, k, dest[k], 0);
    chk({tag, "_valid_ill"}, k, {exv[k], ill[k]}, 0);
  endtask

  task automatic compare(input int k, input exp_t e, input logic s);
    chk("stall", k, s, e.stall);
    chk("exvalid", k, exv[k], e.valid);
    chk("illegalop", k, ill[k], e.ill);
    chk("memread", k, mr[k], e.mr);
    chk("memwrite", k, mw[k], e.mw);
    chk("regwrite", k, rw[k], e.rw);
    chk("alusrc", k, asrc[k], e.asrc);
    chk("isbr_isimm_sob", k, {isbr[k], isimm[k], sob[k]}, {e.isbr, e.isimm, e.sob});
    chk("aluop", k, alu[k], e.alu);
    chk("brcmd", k, br[k], e.br);
    if (e.dcare) chk("exdest", k, dest[k], e.dest);
  endtask

  initial begin : monitor
    logic s0, s1;
    exp_t e;
    forever begin
      @(negedge clk);
      #3 s0 = stall_o[0];
      s1 = stall_o[1];
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin e = q0.pop_front(); compare(0, e, s0); end
      if (q1.size() > 0) begin e = q1.pop_front(); compare(1, e, s1); end
    end
  end

  task automatic run_phase(input int k);
    int  ns;
    bit  st;
    logic [5:0] o, f;
    int  s, t, d;
    bit  v, fls;
    send(k, 6'b100011, '0, 1, 8, 0, ns);
    chk("lw_ex", k, {mr[k], rw[k], alu[k], dest[k]}, {1'b1, 1'b1, 3'd2, 5'd8});
    send(k, 6'b000000, 6'b100000, 8, 2, 9, ns);
    chk("loaduse_stall_cycles", k, ns, ls[k]);
    chk("add_after_stall", k, {exv[k], alu[k], dest[k]}, {1'b1, 3'd2, 5'd9});
    send(k, 6'b001101, '0, 0, 5, 0, ns);
    if (imm_en[k]) chk("ori_ex", k, {asrc[k], alu[k], dest[k], ill[k]}, {1'b1, 3'd1, 5'd5, 1'b0});
    else           chk("ori_illegal", k, {exv[k], ill[k]}, {1'b0, 1'b1});
    send(k, 6'b000000, 6'b100000, 1, 2, 0, ns);
    chk("rdest0", k, {exv[k], rw[k]}, {1'b1, 1'b0});
    send(k, 6'b000000, 6'b000111, 1, 2, 3, ns);
    chk("bad_funct", k, {ill[k], exv[k], rw[k], alu[k]}, {1'b1, 1'b0, 1'b0, 3'd0});
    send(k, 6'b000001, '0, 0, 0, 0, ns);
    chk("illegal_one_cycle", k, ill[k], 0);
    send(k, 6'b100011, '0, 1, 0, 0, ns);
    send(k, 6'b000000, 6'b100000, 0, 0, 4, ns);
    chk("lw_r0_no_stall", k, ns, 0);
    send(k, 6'b100011, '0, 1, 8, 0, ns);
    step(k, 6'b000000, 6'b100000, 8, 2, 9, 1'b1, 1'b0, st);
    step(k, 6'b000000, 6'b100000, 8, 2, 9, 1'b1, 1'b1, st);
    chk("flush_kills_stall", k, last_dut_stall, 0);
    send(k, 6'b000000, 6'b100010, 3, 4, 7, ns);
    chk("after_flush", k, {ns, 32'(alu[k]), 32'(dest[k])}, {32'd0, 32'd3, 32'd7});
    step(k, 6'b100011, '0, 1, 2, 0, 1'b0, 1'b0, st);
    st = 1'b0;
    o = '0; f = '0; s = 0; t = 0; d = 0; v = 1'b1;
    for (int i = 0; i < 250; i++) begin
      if (!st) begin
        o = ops[$urandom_range(0, 13)];
        f = fns[$urandom_range(0, 5)];
        s = $urandom_range(0, 3);
        t = $urandom_range(0, 3);
        d = $urandom_range(0, 3);
        v = ($urandom_range(0, 9) != 0);
      end
      fls = ($urandom_range(0, 11) == 0);
      step(k, o, f, s, t, d, v, fls, st);
    end
  endtask

  initial begin : main
    int ns;
    bit st;
    Rst = 1'b0;
    idle_inputs();
    model_reset();
    for (int k = 0; k < 2; k++) begin
      op[k] = 6'b100011; rs[k] = 5'd1; rt[k] = 5'd8; idv[k] = 1'b1;
    end
    @(posedge clk);
    #2;
    for (int k = 0; k < 2; k++) check_cleared(k, "reset");
    @(negedge clk);
    Rst = 1'b1;
    idle_inputs();

    for (int k = 0; k < 2; k++) begin
      do_reset();
      run_phase(k);
    end

    do_reset();
    send(1, 6'b100011, '0, 1, 8, 0, ns);
    step(1, 6'b000000, 6'b100000, 8, 2, 9, 1'b1, 1'b0, st);
    #2 Rst = 1'b0;
    #1 check_cleared(1, "midstall_reset");
    @(negedge clk);
    Rst = 1'b1;
    model_reset();
    send(1, 6'b000000, 6'b100000, 8, 2, 9, ns);
    chk("post_reset_no_stall", 1, ns, 0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 0, q0.size() + q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
